// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl: jump FSM, obstacle lanes, LFSR spawner, collision and
// score sequencer driving the six seven-segment digits of the dino game.
module dino_game_ctrl #(
    parameter int unsigned TICK_DIV  = 12_500_000,
    parameter int unsigned AIR_TICKS = 3,
    parameter int unsigned MIN_GAP   = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        jump_i,
    output logic [41:0] hex_o,
    output logic [13:0] score_o,
    output logic        running_o,
    output logic        game_over_o,
    output logic        tick_o
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = ($clog2(AIR_TICKS + 1) < 2) ? 2 : $clog2(AIR_TICKS + 1);
    localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

    localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
    localparam logic [AW-1:0] AIR_LD  = AW'(AIR_TICKS);
    localparam logic [GW-1:0] GAP_MIN = GW'(MIN_GAP);

    localparam logic [6:0] P_BOT  = 7'b0100011;
    localparam logic [6:0] P_TOP  = 7'b0011100;
    localparam logic [6:0] CACTUS = 7'b1110111;
    localparam logic [6:0] BIRD   = 7'b1111110;
    localparam logic [6:0] OFF    = 7'h7F;

    localparam logic [1:0] L_NONE   = 2'b00;
    localparam logic [1:0] L_CACTUS = 2'b01;
    localparam logic [1:0] L_BIRD   = 2'b10;

    localparam logic [41:0] IDLE_IMG = {P_BOT, {5{OFF}}};
    localparam logic [13:0] SCORE_MAX = 14'd9999;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [4:0][1:0] lane_q, lane_d;
    logic            air_q, air_d;
    logic [AW-1:0]   air_cnt_q, air_cnt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [13:0]     score_q, score_d;
    logic [41:0]     hex_q, hex_d;

    logic            jump_meta_q, jump_sync_q, jump_prev_q;
    logic            jump_edge;
    logic            tick;
    logic            air_now;
    logic            collide;
    logic            spawn;
    logic            lfsr_fb;
    logic [1:0]      exiting;
    logic [1:0]      spawn_code;

    function automatic logic [6:0] glyph(input logic [1:0] code);
        case (code)
            L_CACTUS: glyph = CACTUS;
            L_BIRD:   glyph = BIRD;
            default:  glyph = OFF;
        endcase
    endfunction

    // Two-flop synchroniser plus a history flop for rising-edge detect.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            jump_meta_q <= 1'b0;
            jump_sync_q <= 1'b0;
            jump_prev_q <= 1'b0;
        end else begin
            jump_meta_q <= jump_i;
            jump_sync_q <= jump_meta_q;
            jump_prev_q <= jump_sync_q;
        end
    end

    assign jump_edge  = jump_sync_q & ~jump_prev_q;
    assign tick       = (state_q == S_RUN) && (div_q == DIV_MAX);
    assign air_now    = air_q | ((state_q == S_RUN) & jump_edge);
    assign exiting    = lane_q[0];
    assign collide    = tick && (((exiting == L_CACTUS) && !air_now) ||
                                 ((exiting == L_BIRD) && air_now));
    assign spawn      = (gap_q >= GAP_MIN) && lfsr_q[0];
    assign spawn_code = spawn ? (lfsr_q[1] ? L_BIRD : L_CACTUS) : L_NONE;
    assign lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            lane_q    <= '0;
            air_q     <= 1'b0;
            air_cnt_q <= '0;
            gap_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            score_q   <= '0;
            hex_q     <= IDLE_IMG;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            lane_q    <= lane_d;
            air_q     <= air_d;
            air_cnt_q <= air_cnt_d;
            gap_q     <= gap_d;
            lfsr_q    <= lfsr_d;
            score_q   <= score_d;
            hex_q     <= hex_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        lane_d    = lane_q;
        air_d     = air_q;
        air_cnt_d = air_cnt_q;
        gap_d     = gap_q;
        lfsr_d    = lfsr_q;
        score_d   = score_q;
        hex_d     = hex_q;

        unique case (state_q)
            S_IDLE: begin
                div_d = '0;
                hex_d = IDLE_IMG;
                if (jump_edge) begin
                    state_d   = S_RUN;
                    lane_d    = '0;
                    score_d   = '0;
                    gap_d     = '0;
                    air_d     = 1'b0;
                    air_cnt_d = '0;
                end
            end

            S_RUN: begin
                div_d = tick ? '0 : div_q + DW'(1);
                hex_d = {air_q ? P_TOP : P_BOT,
                         glyph(lane_q[0]), glyph(lane_q[1]),
                         glyph(lane_q[2]), glyph(lane_q[3]),
                         glyph(lane_q[4])};

                if (jump_edge && !air_q) begin
                    air_d     = 1'b1;
                    air_cnt_d = AIR_LD;
                end

                // A hit freezes the whole playfield as it stood on the tick.
                if (collide) begin
                    state_d   = S_OVER;
                    div_d     = '0;
                    air_d     = air_q;
                    air_cnt_d = air_cnt_q;
                end else if (tick) begin
                    lane_d = {spawn_code, lane_q[4:1]};
                    lfsr_d = {lfsr_fb, lfsr_q[15:1]};
                    if (spawn) begin
                        gap_d = '0;
                    end else if (gap_q < GAP_MIN) begin
                        gap_d = gap_q + GW'(1);
                    end
                    if ((exiting != L_NONE) && (score_q != SCORE_MAX)) begin
                        score_d = score_q + 14'd1;
                    end
                    if (air_q) begin
                        if (air_cnt_q <= AW'(1)) begin
                            air_d     = 1'b0;
                            air_cnt_d = '0;
                        end else begin
                            air_cnt_d = air_cnt_q - AW'(1);
                        end
                    end
                end
            end

            S_OVER: begin
                div_d = '0;
                if (jump_edge) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                div_d   = '0;
            end
        endcase
    end

    assign hex_o       = hex_q;
    assign score_o     = score_q;
    assign running_o   = (state_q == S_RUN);
    assign game_over_o = (state_q == S_OVER);
    assign tick_o      = tick;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Directed bench for dino_game_ctrl: a tick-level game model predicts
// lanes, score and player so each tick's display can be checked.
module tb_dino_game_ctrl;

    localparam int TD = 4;
    localparam int AT = 3;
    localparam int MG = 2;

    localparam logic [6:0] P_BOT  = 7'b0100011;
    localparam logic [6:0] P_TOP  = 7'b0011100;
    localparam logic [6:0] CACTUS = 7'b1110111;
    localparam logic [6:0] BIRD   = 7'b1111110;
    localparam logic [6:0] OFF    = 7'h7F;
    localparam logic [41:0] IDLE_IMG = {P_BOT, {5{OFF}}};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump = 1'b0;
    logic [41:0] hex;
    logic [13:0] score;
    logic        running;
    logic        over;
    logic        tick;

    int total = 0;
    int bad   = 0;

    logic [1:0]  m_lane [5];
    logic [15:0] m_lfsr;
    int          m_gap;
    int          m_score;
    int          m_cnt;
    bit          m_air;
    bit          m_over;

    always #5 clk = ~clk;

    dino_game_ctrl #(
        .TICK_DIV (TD),
        .AIR_TICKS(AT),
        .MIN_GAP  (MG),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .jump_i     (jump),
        .hex_o      (hex),
        .score_o    (score),
        .running_o  (running),
        .game_over_o(over),
        .tick_o     (tick)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] g(input logic [1:0] c);
        if (c == 2'b01) return CACTUS;
        if (c == 2'b10) return BIRD;
        return OFF;
    endfunction

    function automatic logic [41:0] m_img();
        return {m_air ? P_TOP : P_BOT, g(m_lane[0]), g(m_lane[1]),
                g(m_lane[2]), g(m_lane[3]), g(m_lane[4])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_lane[i] = 2'b00;
        m_lfsr  = 16'hACE1;
        m_gap   = 0;
        m_score = 0;
        m_cnt   = 0;
        m_air   = 0;
        m_over  = 0;
    endtask

    task automatic model_jump();
        if (!m_air) begin
            m_air = 1;
            m_cnt = AT;
        end
    endtask

    task automatic model_tick();
        logic [1:0] ex;
        logic fb;
        ex = m_lane[0];
        if ((ex == 2'b01 && !m_air) || (ex == 2'b10 && m_air)) begin
            m_over = 1;
            return;
        end
        if (ex != 2'b00 && m_score < 9999) m_score++;
        for (int i = 0; i < 4; i++) m_lane[i] = m_lane[i+1];
        if (m_gap >= MG && m_lfsr[0]) begin
            m_lane[4] = m_lfsr[1] ? 2'b10 : 2'b01;
            m_gap = 0;
        end else begin
            m_lane[4] = 2'b00;
            if (m_gap < MG) m_gap++;
        end
        fb = ((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'd1;
        m_lfsr = (m_lfsr >> 1) | (16'(fb) << 15);
        if (m_air) begin
            m_cnt--;
            if (m_cnt == 0) m_air = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        jump  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_tick(input bit release_jump, output bit ok, output int n);
        ok = 0;
        n  = 0;
        while (!ok && n < 12) begin
            @(negedge clk);
            n++;
            if (n == 1 && release_jump) jump = 1'b0;
            if (tick === 1'b1) ok = 1;
        end
    endtask

    task automatic start_game();
        @(negedge clk);
        jump = 1'b1;
        @(negedge clk);
        jump = 1'b0;
        @(negedge clk);
        total++;
        if (running !== 1'b0) begin
            bad++;
            $display("FAIL start_latency got=%b want=0", running);
        end
        @(negedge clk);
        total++;
        if (running !== 1'b1) begin
            bad++;
            $display("FAIL start_running got=%b want=1", running);
        end
        total++;
        if (score !== 14'd0) begin
            bad++;
            $display("FAIL start_score got=%0d want=0", score);
        end
    endtask

    // mode: 0 never jump, 1 jump for cactus in lane0, 2 jump for cactus
    // in lane1, 3 jump for anything in lane0, 4 hold jump, 5 pulse every 2 ticks
    task automatic play(input int mode, input int nticks, input int exp_over,
                        input logic [6:0] exp_glyph, output int ptop);
        bit ok;
        int n;
        int last_spawn;
        ptop = 0;
        last_spawn = -1;
        wait_tick(1'b1, ok, n);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL first_tick got=none want=tick");
            return;
        end
        for (int t = 0; t < nticks; t++) begin
            total++;
            if (hex !== m_img()) begin
                bad++;
                $display("FAIL hex t=%0d got=%h want=%h", t, hex, m_img());
            end
            total++;
            if (score !== 14'(m_score)) begin
                bad++;
                $display("FAIL score t=%0d got=%0d want=%0d", t, score, m_score);
            end
            if (hex[41:35] == P_TOP) ptop++;
            if (hex[6:0] != OFF) begin
                if (last_spawn >= 0) begin
                    total++;
                    if (t - last_spawn < MG + 1) begin
                        bad++;
                        $display("FAIL spawn_gap got=%0d want>=%0d", t - last_spawn, MG + 1);
                    end
                end
                last_spawn = t;
            end
            model_tick();
            if (m_over) begin
                jump = 1'b0;
                @(negedge clk);
                total++;
                if (over !== 1'b1) begin
                    bad++;
                    $display("FAIL over_flag got=%b want=1", over);
                end
                total++;
                if (running !== 1'b0) begin
                    bad++;
                    $display("FAIL over_running got=%b want=0", running);
                end
                for (int c = 0; c < 20 * TD; c++) begin
                    @(negedge clk);
                    total++;
                    if (tick !== 1'b0) begin
                        bad++;
                        $display("FAIL over_tick c=%0d got=%b want=0", c, tick);
                    end
                end
                total++;
                if (hex !== m_img()) begin
                    bad++;
                    $display("FAIL frozen_hex got=%h want=%h", hex, m_img());
                end
                total++;
                if (score !== 14'(m_score)) begin
                    bad++;
                    $display("FAIL frozen_score got=%0d want=%0d", score, m_score);
                end
                total++;
                if (exp_over == 0) begin
                    bad++;
                    $display("FAIL unexpected_over got=1 want=0");
                end else if (exp_over == 1) begin
                    total++;
                    if (hex[34:28] !== exp_glyph) begin
                        bad++;
                        $display("FAIL hit_kind got=%b want=%b", hex[34:28], exp_glyph);
                    end
                    if (hex[41:35] !== ((exp_glyph == BIRD) ? P_TOP : P_BOT)) begin
                        bad++;
                        $display("FAIL hit_player got=%b want=%b", hex[41:35],
                                 (exp_glyph == BIRD) ? P_TOP : P_BOT);
                    end
                end
                return;
            end
            if (mode == 1 && m_lane[0] == 2'b01 && !m_air) begin
                jump = 1'b1;
                model_jump();
            end else if (mode == 2 && m_lane[1] == 2'b01 && !m_air) begin
                jump = 1'b1;
                model_jump();
            end else if (mode == 3 && m_lane[0] != 2'b00 && !m_air) begin
                jump = 1'b1;
                model_jump();
            end else if (mode == 4 && t == 0) begin
                jump = 1'b1;
                model_jump();
            end else if (mode == 5 && (t % 2) == 0) begin
                jump = 1'b1;
                model_jump();
            end
            wait_tick(mode != 4, ok, n);
            total++;
            if (!ok || n != TD) begin
                bad++;
                $display("FAIL tick_period t=%0d got=%0d want=%0d", t, ok ? n : -1, TD);
                jump = 1'b0;
                return;
            end
        end
        jump = 1'b0;
        if (exp_over == 1) begin
            total++;
            bad++;
            $display("FAIL no_collision got=running want=over");
        end else if (exp_over == 0) begin
            total++;
            if (running !== 1'b1) begin
                bad++;
                $display("FAIL still_running got=%b want=1", running);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (hex !== IDLE_IMG) begin
            bad++;
            $display("FAIL reset_hex got=%h want=%h", hex, IDLE_IMG);
        end
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            total++;
            if (tick !== 1'b0 || running !== 1'b0) begin
                bad++;
                $display("FAIL idle_quiet c=%0d got=%b%b want=00", c, tick, running);
            end
        end
        total++;
        if (hex !== IDLE_IMG) begin
            bad++;
            $display("FAIL idle_hex got=%h want=%h", hex, IDLE_IMG);
        end
        total++;
        if (over !== 1'b0 || score !== 14'd0) begin
            bad++;
            $display("FAIL idle_state got=%b/%0d want=0/0", over, score);
        end
    endtask

    task automatic test_run_ticks();
        int p;
        do_reset();
        start_game();
        play(1, 14, 0, OFF, p);
    endtask

    task automatic test_cactus_hit();
        int p;
        do_reset();
        start_game();
        play(0, 60, 1, CACTUS, p);
    endtask

    task automatic test_jump_early();
        int p;
        do_reset();
        start_game();
        play(2, 30, 0, OFF, p);
        total++;
        if (score < 14'd1) begin
            bad++;
            $display("FAIL early_jump_score got=%0d want>=1", score);
        end
    endtask

    task automatic test_bird_air();
        int p;
        do_reset();
        start_game();
        play(3, 60, 1, BIRD, p);
    endtask

    task automatic test_over_to_idle();
        @(negedge clk);
        jump = 1'b1;
        @(negedge clk);
        jump = 1'b0;
        @(negedge clk);
        total++;
        if (over !== 1'b1) begin
            bad++;
            $display("FAIL over_hold got=%b want=1", over);
        end
        @(negedge clk);
        total++;
        if (over !== 1'b0 || running !== 1'b0) begin
            bad++;
            $display("FAIL over_to_idle got=%b%b want=00", over, running);
        end
        @(negedge clk);
        total++;
        if (hex !== IDLE_IMG) begin
            bad++;
            $display("FAIL idle_image got=%h want=%h", hex, IDLE_IMG);
        end
    endtask

    task automatic test_reset_midair();
        bit ok;
        int n;
        int p;
        do_reset();
        start_game();
        wait_tick(1'b1, ok, n);
        jump = 1'b1;
        @(negedge clk);
        jump = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (hex[41:35] !== P_TOP) begin
            bad++;
            $display("FAIL midair_top got=%b want=%b", hex[41:35], P_TOP);
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (hex !== IDLE_IMG || score !== 14'd0) begin
            bad++;
            $display("FAIL midair_reset got=%h/%0d want=%h/0", hex, score, IDLE_IMG);
        end
        total++;
        if (running !== 1'b0 || over !== 1'b0 || tick !== 1'b0) begin
            bad++;
            $display("FAIL midair_flags got=%b%b%b want=000", running, over, tick);
        end
        rst_n = 1'b1;
        model_reset();
        start_game();
        play(1, 16, 0, OFF, p);
    endtask

    task automatic test_jump_held();
        int p;
        do_reset();
        start_game();
        play(4, 10, 2, OFF, p);
        total++;
        if (p != AT) begin
            bad++;
            $display("FAIL held_jump_air got=%0d want=%0d", p, AT);
        end
    endtask

    task automatic test_no_double_jump();
        int p;
        do_reset();
        start_game();
        play(5, 20, 2, OFF, p);
    endtask

    initial begin
        test_reset();
        test_run_ticks();
        test_cactus_hit();
        test_jump_early();
        test_bird_air();
        test_over_to_idle();
        test_reset_midair();
        test_jump_held();
        test_no_double_jump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
